// File: rtl/mdio_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdio_req_sequencer
// Purpose  : Turns host read/write/RMW/poll requests into MDIO master
//            transactions, with a read-response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_req_sequencer #(
    parameter int POLL_MAX   = 255,
    parameter int POLL_GAP   = 1000,
    parameter int RD_TIMEOUT = 65535
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic        req_clause_i,
    input  logic [25:0] req_addr_i,
    input  logic [15:0] req_data_i,
    input  logic [15:0] req_mask_i,
    output logic        resp_valid_o,
    output logic [15:0] resp_data_o,
    output logic [1:0]  resp_status_o,
    output logic        busy_o,
    output logic        m_clause_sel_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [1:0]  m_cmd_o,
    output logic [25:0] m_addr_o,
    output logic [15:0] m_wdata_o,
    input  logic        m_rdata_vld_i,
    input  logic [15:0] m_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR_ISSUE = 3'd3,
        S_WR_WAIT  = 3'd4,
        S_GAP      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [1:0]  C_OP_WR    = 2'b01;
    localparam logic [1:0]  C_OP_RMW   = 2'b10;
    localparam logic [1:0]  C_OP_POLL  = 2'b11;
    localparam logic [1:0]  C_CMD_WR   = 2'b01;
    localparam logic [1:0]  C_CMD_RD   = 2'b11;
    localparam logic [1:0]  C_ST_OK    = 2'b00;
    localparam logic [1:0]  C_ST_LIMIT = 2'b01;
    localparam logic [1:0]  C_ST_TMO   = 2'b10;
    localparam logic [15:0] C_TMO_LAST = 16'(RD_TIMEOUT - 1);
    localparam logic [15:0] C_GAP_LAST = 16'(POLL_GAP - 1);
    localparam logic [7:0]  C_POLL_MAX = 8'(POLL_MAX);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [15:0] r_data;
    logic [15:0] r_mask;
    logic [15:0] r_cnt;
    logic [7:0]  r_attempts;
    logic        r_seen_low;

    logic        w_accept;
    logic [15:0] w_merge;
    logic        w_match;

    assign w_accept = req_valid_i && req_ready_o;
    assign w_merge  = (m_rdata_i & ~r_mask) | (r_data & r_mask);
    assign w_match  = ((m_rdata_i ^ r_data) & r_mask) == 16'd0;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state        <= S_IDLE;
            r_op           <= 2'b00;
            r_data         <= 16'd0;
            r_mask         <= 16'd0;
            r_cnt          <= 16'd0;
            r_attempts     <= 8'd0;
            r_seen_low     <= 1'b0;
            req_ready_o    <= 1'b0;
            resp_valid_o   <= 1'b0;
            resp_data_o    <= 16'd0;
            resp_status_o  <= C_ST_OK;
            busy_o         <= 1'b0;
            m_valid_o      <= 1'b0;
            m_cmd_o        <= C_CMD_RD;
            m_addr_o       <= 26'd0;
            m_wdata_o      <= 16'd0;
            m_clause_sel_o <= 1'b0;
        end else begin
            resp_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (w_accept) begin
                        req_ready_o    <= 1'b0;
                        busy_o         <= 1'b1;
                        r_op           <= req_op_i;
                        r_data         <= req_data_i;
                        r_mask         <= req_mask_i;
                        r_attempts     <= 8'd0;
                        m_addr_o       <= req_addr_i;
                        m_clause_sel_o <= req_clause_i;
                        m_valid_o      <= 1'b1;
                        if (req_op_i == C_OP_WR) begin
                            r_state   <= S_WR_ISSUE;
                            m_cmd_o   <= C_CMD_WR;
                            m_wdata_o <= req_data_i;
                        end else begin
                            r_state <= S_RD_ISSUE;
                            m_cmd_o <= C_CMD_RD;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (m_valid_o && m_ready_i) begin
                        m_valid_o  <= 1'b0;
                        r_cnt      <= 16'd0;
                        r_attempts <= r_attempts + 8'd1;
                        r_state    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // A strobe on the timeout cycle is still taken as valid data.
                    if (m_rdata_vld_i) begin
                        r_cnt <= 16'd0;
                        if (r_op == C_OP_RMW) begin
                            m_wdata_o <= w_merge;
                            m_cmd_o   <= C_CMD_WR;
                            m_valid_o <= 1'b1;
                            r_state   <= S_WR_ISSUE;
                        end else if (r_op == C_OP_POLL && !w_match && r_attempts != C_POLL_MAX) begin
                            r_state <= S_GAP;
                        end else begin
                            resp_valid_o  <= 1'b1;
                            resp_data_o   <= m_rdata_i;
                            resp_status_o <= (r_op == C_OP_POLL && !w_match) ? C_ST_LIMIT : C_ST_OK;
                            r_state       <= S_DONE;
                        end
                    end else if (r_cnt == C_TMO_LAST) begin
                        resp_valid_o  <= 1'b1;
                        resp_data_o   <= 16'd0;
                        resp_status_o <= C_ST_TMO;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WR_ISSUE: begin
                    if (m_valid_o && m_ready_i) begin
                        m_valid_o  <= 1'b0;
                        r_seen_low <= 1'b0;
                        r_state    <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    // The master drops ready while the frame is on the wire.
                    if (!m_ready_i) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        resp_valid_o  <= 1'b1;
                        resp_data_o   <= m_wdata_o;
                        resp_status_o <= C_ST_OK;
                        r_state       <= S_DONE;
                    end
                end
                S_GAP: begin
                    if (r_cnt == C_GAP_LAST) begin
                        m_valid_o <= 1'b1;
                        m_cmd_o   <= C_CMD_RD;
                        r_state   <= S_RD_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    busy_o      <= 1'b0;
                    req_ready_o <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdio_req_sequencer
// Purpose  : Directed and random requests against a behavioural MDIO master
//            and a request-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_req_sequencer;

    localparam int P_MAX = 3;
    localparam int P_GAP = 20;
    localparam int TO    = 1000;

    logic        clk_i;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic        req_clause_i;
    logic [25:0] req_addr_i;
    logic [15:0] req_data_i;
    logic [15:0] req_mask_i;
    logic        resp_valid_o;
    logic [15:0] resp_data_o;
    logic [1:0]  resp_status_o;
    logic        busy_o;
    logic        m_clause_sel_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [1:0]  m_cmd_o;
    logic [25:0] m_addr_o;
    logic [15:0] m_wdata_o;
    logic        m_rdata_vld_i;
    logic [15:0] m_rdata_i;

    mdio_req_sequencer #(
        .POLL_MAX   (P_MAX),
        .POLL_GAP   (P_GAP),
        .RD_TIMEOUT (TO)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_clause_i   (req_clause_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_mask_i     (req_mask_i),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .resp_status_o  (resp_status_o),
        .busy_o         (busy_o),
        .m_clause_sel_o (m_clause_sel_o),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_cmd_o        (m_cmd_o),
        .m_addr_o       (m_addr_o),
        .m_wdata_o      (m_wdata_o),
        .m_rdata_vld_i  (m_rdata_vld_i),
        .m_rdata_i      (m_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // read plan: mode 0 = strobe after lat, 1 = strobe on timeout cycle,
    // 2 = strobe one cycle too late, 3 = no strobe at all
    logic [15:0] rd_val [8];
    int          rd_lat [8];
    int          rd_mode[8];
    int          wr_busy_force = 0;

    int          mbusy = 0, stall = 0, hs_lat = 1, rd_idx = 0;
    bit          hs_flag = 0, pend_strobe = 0, wr_in_flight = 0;
    logic [15:0] pend_val = 16'd0;
    int          n_rd, n_wr, resp_cnt, resp_cyc, strobe_cyc, last_hs_cyc, min_gap;
    int          bad_cmd, bad_stab, bad_drop, early_resp;
    logic [15:0] resp_d, last_wval;
    logic [1:0]  resp_s;
    logic [25:0] cur_addr;
    logic        cur_clause;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int i, input logic [15:0] v, input int mode, input int lat);
        rd_val[i]  = v;
        rd_mode[i] = mode;
        rd_lat[i]  = lat;
    endtask

    task automatic clear_rd();
        for (int i = 0; i < 8; i++) set_rd(i, 16'h0000, 0, 5);
    endtask

    // One negedge of the behavioural MDIO master plus observation of the DUT.
    task automatic tick();
        m_rdata_vld_i = 1'b0;
        if (resp_valid_o === 1'b1) begin
            resp_cnt++;
            resp_d   = resp_data_o;
            resp_s   = resp_status_o;
            resp_cyc = cyc;
            if (wr_in_flight) early_resp++;
        end
        if (busy_o === 1'b1 && (m_addr_o !== cur_addr || m_clause_sel_o !== cur_clause)) bad_stab++;
        if (hs_flag) begin
            hs_flag = 0;
            if (m_valid_o !== 1'b0) bad_drop++;
            m_ready_i = 1'b0;
            mbusy     = hs_lat;
        end else if (mbusy > 0) begin
            mbusy--;
            if (mbusy == 0) begin
                m_ready_i    = 1'b1;
                wr_in_flight = 0;
                if (pend_strobe) begin
                    m_rdata_vld_i = 1'b1;
                    m_rdata_i     = pend_val;
                    strobe_cyc    = cyc;
                    pend_strobe   = 0;
                end
            end
        end else if (stall > 0) begin
            stall--;
            if (stall == 0) m_ready_i = 1'b1;
        end
        if (m_ready_i === 1'b1 && m_valid_o === 1'b1) begin
            hs_flag = 1;
            if (m_cmd_o === 2'b11) begin
                int idx;
                idx = (rd_idx < 8) ? rd_idx : 7;
                rd_idx++;
                n_rd++;
                if (strobe_cyc >= 0 && cyc - strobe_cyc < min_gap) min_gap = cyc - strobe_cyc;
                last_hs_cyc = cyc;
                pend_val    = rd_val[idx];
                pend_strobe = (rd_mode[idx] != 3);
                case (rd_mode[idx])
                    1:       hs_lat = TO - 1;
                    2:       hs_lat = TO;
                    3:       hs_lat = TO + 3;
                    default: hs_lat = rd_lat[idx];
                endcase
            end else if (m_cmd_o === 2'b01) begin
                n_wr++;
                last_wval    = m_wdata_o;
                wr_in_flight = 1;
                hs_lat       = (wr_busy_force > 0) ? wr_busy_force : int'($urandom_range(1, 6));
            end else begin
                bad_cmd++;
                hs_lat = 1;
            end
        end
    endtask

    task automatic run_req(input logic [1:0] op, input logic clause, input logic [25:0] addr,
                           input logic [15:0] d, input logic [15:0] m, input bit do_rst);
        bit finished, did_rst, rst_pending;
        n_rd = 0; n_wr = 0; resp_cnt = 0; resp_cyc = -1; strobe_cyc = -1; last_hs_cyc = -1;
        min_gap = 1 << 30; bad_cmd = 0; bad_stab = 0; bad_drop = 0; early_resp = 0;
        resp_d = 16'd0; resp_s = 2'd0; last_wval = 16'd0; rd_idx = 0;
        did_rst = 0; rst_pending = 0; finished = 0;
        cur_addr = addr; cur_clause = clause;
        if (mbusy == 0 && !hs_flag) begin
            stall = int'($urandom_range(0, 3));
            if (stall > 0) m_ready_i = 1'b0;
        end
        for (int k = 0; k < 200 && req_ready_o !== 1'b1; k++) begin
            @(negedge clk_i); tick();
        end
        chk("req_ready_before_accept", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_op_i = op; req_clause_i = clause;
        req_addr_i = addr; req_data_i = d; req_mask_i = m;
        @(negedge clk_i); tick();
        req_valid_i = 1'b0; req_op_i = 2'($urandom); req_clause_i = 1'($urandom);
        req_addr_i = 26'($urandom); req_data_i = 16'($urandom); req_mask_i = 16'($urandom);
        chk("ready_busy_after_accept", 32'({req_ready_o, busy_o}), 32'h1);
        for (int k = 0; k < 6000 && !finished; k++) begin
            @(negedge clk_i);
            if (rst_pending) begin
                chk("reset_abort_outputs", 32'({m_valid_o, resp_valid_o, busy_o, req_ready_o}), 32'h0);
                rstn_i = 1'b1; rst_pending = 0; did_rst = 1;
            end
            tick();
            if (do_rst && !did_rst && !rst_pending && wr_in_flight && mbusy >= 2) begin
                rstn_i = 1'b0; rst_pending = 1;
            end
            finished = (resp_cnt > 0 || did_rst) && mbusy == 0 && !hs_flag && !rst_pending;
        end
        chk("request_cycle_bound", 32'(finished), 32'd1);
        repeat (3) begin @(negedge clk_i); tick(); end
    endtask

    // Request-level reference: what the host should see, from the op rules alone.
    task automatic expect_req(input string tag, input logic [1:0] op,
                              input logic [15:0] d, input logic [15:0] m);
        int exp_reads = 0, exp_writes = 0;
        logic [15:0] exp_wval = 16'd0, exp_data = 16'd0;
        logic [1:0]  exp_st = 2'b00;
        if (op == 2'b01) begin
            exp_writes = 1; exp_wval = d; exp_data = d;
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp_reads++;
                if (rd_mode[i] >= 2) begin exp_st = 2'b10; exp_data = 16'd0; break; end
                if (op == 2'b10) begin
                    exp_wval = (rd_val[i] & ~m) | (d & m);
                    exp_writes = 1; exp_data = exp_wval; break;
                end
                if (op == 2'b00 || (rd_val[i] & m) == (d & m)) begin exp_data = rd_val[i]; break; end
                if (exp_reads == P_MAX) begin exp_st = 2'b01; exp_data = rd_val[i]; break; end
            end
        end
        chk({tag, ".resp_count"}, 32'(resp_cnt), 32'd1);
        chk({tag, ".resp_data"}, 32'(resp_d), 32'(exp_data));
        chk({tag, ".resp_status"}, 32'(resp_s), 32'(exp_st));
        chk({tag, ".reads"}, 32'(n_rd), 32'(exp_reads));
        chk({tag, ".writes"}, 32'(n_wr), 32'(exp_writes));
        if (exp_writes > 0) chk({tag, ".wdata"}, 32'(last_wval), 32'(exp_wval));
        chk({tag, ".protocol_errs"}, 32'(bad_cmd + bad_stab + bad_drop + early_resp), 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [15:0] d, m;
        logic [25:0] a;
        rstn_i = 1'b0; req_valid_i = 1'b0; req_op_i = 2'b00; req_clause_i = 1'b0;
        req_addr_i = 26'd0; req_data_i = 16'd0; req_mask_i = 16'd0;
        m_ready_i = 1'b1; m_rdata_vld_i = 1'b0; m_rdata_i = 16'd0;
        clear_rd();
        repeat (3) @(negedge clk_i);
        chk("rst.req_ready", 32'(req_ready_o), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst.resp_data", 32'(resp_data_o), 32'd0);
        chk("rst.resp_status", 32'(resp_status_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.m_valid", 32'(m_valid_o), 32'd0);
        chk("rst.m_cmd", 32'(m_cmd_o), 32'h3);
        chk("rst.m_addr", 32'(m_addr_o), 32'd0);
        chk("rst.m_wdata", 32'(m_wdata_o), 32'd0);
        chk("rst.m_clause", 32'(m_clause_sel_o), 32'd0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("rst.ready_after_release", 32'(req_ready_o), 32'd1);

        // plain read, data returned 700 cycles after the command
        clear_rd(); set_rd(0, 16'h796D, 0, 700);
        d = 16'($urandom); m = 16'($urandom);
        run_req(2'b00, 1'b0, 26'h0210001, d, m, 0);
        expect_req("read", 2'b00, d, m);
        chk("read.resp_after_strobe", 32'(resp_cyc - strobe_cyc), 32'd1);

        // Clause 45 write
        clear_rd(); a = 26'($urandom);
        run_req(2'b01, 1'b1, a, 16'hA5A5, 16'($urandom), 0);
        expect_req("write", 2'b01, 16'hA5A5, 16'h0);

        // read-modify-write
        clear_rd(); set_rd(0, 16'h1234, 0, 17);
        run_req(2'b10, 1'b0, 26'($urandom), 16'h0050, 16'h00F0, 0);
        expect_req("rmw", 2'b10, 16'h0050, 16'h00F0);

        // poll matching on the third read
        clear_rd(); set_rd(0, 16'h0000, 0, 9); set_rd(1, 16'h0000, 0, 12); set_rd(2, 16'h0004, 0, 7);
        run_req(2'b11, 1'b1, 26'($urandom), 16'h0004, 16'h0004, 0);
        expect_req("poll_match", 2'b11, 16'h0004, 16'h0004);
        chk("poll_match.gap_ok", 32'(min_gap >= P_GAP), 32'd1);

        // poll that never matches runs out of attempts
        clear_rd(); set_rd(0, 16'h0000, 0, 4); set_rd(1, 16'h0000, 0, 4); set_rd(2, 16'h0000, 0, 4);
        run_req(2'b11, 1'b0, 26'($urandom), 16'h0004, 16'h0004, 0);
        expect_req("poll_limit", 2'b11, 16'h0004, 16'h0004);
        chk("poll_limit.gap_ok", 32'(min_gap >= P_GAP), 32'd1);

        // read with no completion
        clear_rd(); set_rd(0, 16'hBEEF, 3, 0);
        run_req(2'b00, 1'b0, 26'($urandom), 16'h0, 16'h0, 0);
        expect_req("read_timeout", 2'b00, 16'h0, 16'h0);
        chk("read_timeout.latency", 32'(resp_cyc - last_hs_cyc), 32'(TO + 1));

        // strobe on the very cycle of the timeout
        clear_rd(); set_rd(0, 16'hC0DE, 1, 0);
        run_req(2'b00, 1'b1, 26'($urandom), 16'h0, 16'h0, 0);
        expect_req("read_coincident", 2'b00, 16'h0, 16'h0);
        chk("read_coincident.latency", 32'(resp_cyc - last_hs_cyc), 32'(TO + 1));

        // strobe one cycle after the timeout
        clear_rd(); set_rd(0, 16'h5A5A, 2, 0);
        run_req(2'b00, 1'b0, 26'($urandom), 16'h0, 16'h0, 0);
        expect_req("read_late", 2'b00, 16'h0, 16'h0);

        // RMW whose read times out must not write
        clear_rd(); set_rd(0, 16'h1111, 3, 0);
        run_req(2'b10, 1'b0, 26'($urandom), 16'hFFFF, 16'h0F0F, 0);
        expect_req("rmw_timeout", 2'b10, 16'hFFFF, 16'h0F0F);

        // reset during WR_WAIT, then a normal read
        clear_rd(); wr_busy_force = 8;
        run_req(2'b01, 1'b1, 26'($urandom), 16'h6C6C, 16'h0, 1);
        wr_busy_force = 0;
        chk("reset_abort.resp_count", 32'(resp_cnt), 32'd0);
        clear_rd(); set_rd(0, 16'h0F1E, 0, 11);
        run_req(2'b00, 1'b0, 26'($urandom), 16'h0, 16'h0, 0);
        expect_req("read_after_reset", 2'b00, 16'h0, 16'h0);

        // random requests
        for (int t = 0; t < 12; t++) begin
            op = 2'($urandom_range(0, 3)); d = 16'($urandom); m = 16'($urandom);
            clear_rd();
            for (int i = 0; i < P_MAX; i++) begin
                logic [15:0] v;
                v = 16'($urandom);
                if ($urandom_range(0, 2) == 0) v = (v & ~m) | (d & m);
                set_rd(i, v, ($urandom_range(0, 9) == 0) ? 3 : 0, int'($urandom_range(1, 40)));
            end
            run_req(op, 1'($urandom), 26'($urandom), d, m, 0);
            expect_req($sformatf("rand%0d_op%0d", t, op), op, d, m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
